// File: rtl/frame_write_ctrl.sv
// Write-port controller for the frame buffer: arbitrates camera capture and a constant-colour clear engine.
// Latency: a write decided in cycle t drives regwrite/addr_in/data_in in cycle t+1; done follows the last write by one cycle.
// Backpressure: none; the buffer accepts one write per cycle, and px_valid gaps simply stall the pixel counter.
module frame_write_ctrl #(
    parameter int AW   = 15,
    parameter int DW   = 3,
    parameter int NPIX = 19200
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cap_req,
    input  logic          clr_req,
    input  logic [DW-1:0] clr_color,
    input  logic          frame_start,
    input  logic          px_valid,
    input  logic [DW-1:0] px_data,
    output logic          regwrite,
    output logic [AW-1:0] addr_in,
    output logic [DW-1:0] data_in,
    output logic          busy,
    output logic          done,
    output logic          short_frame
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_SOF = 3'd1,
        S_CAPTURE  = 3'd2,
        S_CLEAR    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // Address of the final pixel; the counter parks here instead of wrapping.
    localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   col_q, col_d;
    logic            short_q, short_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    // Next-state, counter and write-decision logic for the whole controller.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        col_d   = col_q;
        short_d = short_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;

        unique case (state_q)
            S_IDLE: begin
                // Clear wins when both requests are present.
                if (clr_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                    col_d   = clr_color;
                end else if (cap_req) begin
                    state_d = S_WAIT_SOF;
                    short_d = 1'b0;
                end
            end

            S_WAIT_SOF: begin
                // Pixels before the first frame boundary belong to a partial frame and are dropped.
                if (frame_start) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                end
            end

            S_CAPTURE: begin
                if (frame_start) begin
                    // Camera restarted mid-frame: begin again at pixel 0 and flag it.
                    cnt_d   = '0;
                    short_d = 1'b1;
                end else if (px_valid) begin
                    we_d   = 1'b1;
                    addr_d = cnt_q;
                    data_d = px_data;
                    if (cnt_q == LAST_PIX) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end

            S_CLEAR: begin
                we_d   = 1'b1;
                addr_d = cnt_q;
                data_d = col_q;
                if (cnt_q == LAST_PIX) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs trail the state by one cycle, matching the registered write port.
    always_comb begin
        done_d = (state_q == S_DONE);
        // Stay busy through the done pulse so busy drops only once done has been seen.
        busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
    end

    // Control state: FSM, pixel counter, latched colour and sticky short-frame flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            col_q   <= '0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            short_q <= short_d;
        end
    end

    // Registered buffer write port and status pulses, stable for the buffer's falling-edge write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end

    assign regwrite    = we_q;
    assign addr_in     = addr_q;
    assign data_in     = data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign short_frame = short_q;

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Bench for frame_write_ctrl: small 8-pixel instance for detailed sequences, full-size instance for the long clear.
// Latency: expectations carry the exact cycle each write/done must appear in.
// Backpressure: none; stimulus is cycle-driven.
module tb_frame_write_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small instance signals.
    logic       reset;
    logic       cap_req, clr_req;
    logic [2:0] clr_color;
    logic       frame_start, px_valid;
    logic [2:0] px_data;
    logic       regwrite;
    logic [3:0] addr_in;
    logic [2:0] data_in;
    logic       busy, done, short_frame;

    // Full-size instance signals.
    logic        b_clr_req;
    logic [2:0]  b_clr_color;
    logic        b_regwrite;
    logic [14:0] b_addr_in;
    logic [2:0]  b_data_in;
    logic        b_busy, b_done, b_short_frame;
    logic        b_zero;

    frame_write_ctrl #(.AW(4), .DW(3), .NPIX(8)) u_dut (
        .clk(clk), .reset(reset), .cap_req(cap_req), .clr_req(clr_req),
        .clr_color(clr_color), .frame_start(frame_start), .px_valid(px_valid),
        .px_data(px_data), .regwrite(regwrite), .addr_in(addr_in), .data_in(data_in),
        .busy(busy), .done(done), .short_frame(short_frame)
    );

    frame_write_ctrl #(.AW(15), .DW(3), .NPIX(19200)) u_big (
        .clk(clk), .reset(reset), .cap_req(b_zero), .clr_req(b_clr_req),
        .clr_color(b_clr_color), .frame_start(b_zero), .px_valid(b_zero),
        .px_data(3'b000), .regwrite(b_regwrite), .addr_in(b_addr_in), .data_in(b_data_in),
        .busy(b_busy), .done(b_done), .short_frame(b_short_frame)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t wq[$];
    int  dq[$];
    wr_t mon_e;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_wr(input int a, input int d, input int c);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        wq.push_back(e);
    endtask

    // Full 8-pixel clear granted in cycle k.
    task automatic expect_clear(input int col, input int k);
        for (int i = 0; i < 8; i++) expect_wr(i, col, k + 2 + i);
        dq.push_back(k + 10);
    endtask

    // Drive one valid pixel this cycle; its write must appear next cycle.
    task automatic pixel(input int a, input int d);
        px_valid = 1'b1;
        px_data  = 3'(d);
        expect_wr(a, d, cyc + 1);
        tick(1);
    endtask

    // Scoreboard monitor: every write and done pulse must match the head of its queue.
    always @(negedge clk) begin
        if (regwrite) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %0d at cycle %0d, none expected",
                         addr_in, data_in, cyc);
            end else begin
                mon_e = wq.pop_front();
                check("wr_addr", int'(addr_in), mon_e.addr);
                check("wr_data", int'(data_in), mon_e.data);
                check("wr_cycle", cyc, mon_e.cyc);
            end
        end
        if (done) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: at cycle %0d, none expected", cyc);
            end else begin
                check("done_cycle", cyc, dq.pop_front());
            end
        end
    end

    // Full-size clear observer.
    int b_exp = 0;
    int b_bad = 0;
    int b_done_cnt = 0;
    int b_done_cyc = -1;
    always @(negedge clk) begin
        if (b_regwrite) begin
            if (int'(b_addr_in) != b_exp) b_bad++;
            if (b_data_in != b_clr_color) b_bad++;
            b_exp++;
        end
        if (b_done) begin
            b_done_cnt++;
            b_done_cyc = cyc;
        end
    end

    initial begin
        int k;
        reset       = 1'b1;
        cap_req     = 1'b0;
        clr_req     = 1'b0;
        clr_color   = 3'b000;
        frame_start = 1'b0;
        px_valid    = 1'b0;
        px_data     = 3'b000;
        b_clr_req   = 1'b0;
        b_clr_color = 3'b011;
        b_zero      = 1'b0;

        tick(2);
        check("rst_regwrite", int'(regwrite), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_short", int'(short_frame), 0);
        reset = 1'b0;
        tick(2);
        check("idle_busy", int'(busy), 0);

        // Reset mid-clear at cnt=3: writes 0 and 1 land, the one on the bus is killed.
        k = cyc;
        clr_color = 3'b110;
        clr_req   = 1'b1;
        expect_wr(0, 6, k + 2);
        expect_wr(1, 6, k + 3);
        tick(1);
        clr_req = 1'b0;
        check("clr_grant_busy", int'(busy), 1);
        tick(3);
        reset = 1'b1;
        #1;
        check("arst_regwrite", int'(regwrite), 0);
        check("arst_addr", int'(addr_in), 0);
        check("arst_data", int'(data_in), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_short", int'(short_frame), 0);
        tick(1);
        reset = 1'b0;
        tick(3);
        check("post_rst_busy", int'(busy), 0);

        // Clear with colour 5.
        k = cyc;
        clr_color = 3'b101;
        clr_req   = 1'b1;
        expect_clear(5, k);
        tick(1);
        clr_req = 1'b0;
        check("clr_busy_start", int'(busy), 1);
        tick(9);
        check("clr_busy_at_done", int'(busy), 1);
        tick(1);
        check("clr_busy_after", int'(busy), 0);
        check("clr_addr_hold", int'(addr_in), 7);
        check("clr_data_hold", int'(data_in), 5);

        // Capture with px_valid gaps; px_valid in WAIT_SOF must not write.
        cap_req = 1'b1;
        tick(1);
        cap_req = 1'b0;
        check("cap_grant_busy", int'(busy), 1);
        px_valid = 1'b1;
        px_data  = 3'd6;
        tick(2);
        frame_start = 1'b1;
        px_data     = 3'd7;
        tick(1);
        frame_start = 1'b0;
        for (int n = 0; n < 8; n++) begin
            pixel(n, n);
            if (n == 7) dq.push_back(cyc + 1);
            px_valid = 1'b0;
            tick(1);
        end
        tick(2);
        check("cap_short", int'(short_frame), 0);
        check("cap_busy_end", int'(busy), 0);

        // Short frame: restart after 5 pixels, second pass starts over at 0.
        cap_req = 1'b1;
        tick(1);
        cap_req = 1'b0;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        for (int n = 0; n < 5; n++) pixel(n, 7 - n);
        check("short_before", int'(short_frame), 0);
        frame_start = 1'b1;
        px_valid    = 1'b1;
        px_data     = 3'd1;
        tick(1);
        frame_start = 1'b0;
        check("short_set", int'(short_frame), 1);
        for (int n = 0; n < 8; n++) pixel(n, n ^ 3);
        dq.push_back(cyc + 1);
        px_valid = 1'b0;
        tick(3);
        check("short_sticky", int'(short_frame), 1);
        check("short_busy_end", int'(busy), 0);

        // Both requests: clear first, held cap_req starts WAIT_SOF right after done.
        k = cyc;
        clr_color = 3'b011;
        clr_req   = 1'b1;
        cap_req   = 1'b1;
        expect_clear(3, k);
        tick(1);
        clr_req = 1'b0;
        tick(9);
        check("prio_short_at_done", int'(short_frame), 1);
        check("prio_busy_at_done", int'(busy), 1);
        tick(1);
        check("prio_cap_grant_short", int'(short_frame), 0);
        check("prio_cap_busy", int'(busy), 1);
        cap_req  = 1'b0;
        px_valid = 1'b1;
        px_data  = 3'd5;
        tick(2);
        px_valid    = 1'b0;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        for (int n = 0; n < 8; n++) pixel(n, (3 * n) & 7);
        dq.push_back(cyc + 1);
        px_valid = 1'b0;
        tick(3);
        check("prio_busy_end", int'(busy), 0);

        // cap_req pulse during a clear is dropped.
        k = cyc;
        clr_color = 3'b010;
        clr_req   = 1'b1;
        expect_clear(2, k);
        tick(1);
        clr_req = 1'b0;
        tick(2);
        cap_req = 1'b1;
        tick(1);
        cap_req = 1'b0;
        tick(6);
        check("pulse_busy_at_done", int'(busy), 1);
        tick(1);
        check("pulse_busy_after", int'(busy), 0);
        tick(1);
        check("pulse_busy_stays", int'(busy), 0);

        // Full-size clear.
        k = cyc;
        b_clr_req = 1'b1;
        tick(1);
        b_clr_req = 1'b0;
        check("big_busy_start", int'(b_busy), 1);
        tick(19205);
        check("big_write_count", b_exp, 19200);
        check("big_bad_writes", b_bad, 0);
        check("big_done_count", b_done_cnt, 1);
        check("big_done_cycle", b_done_cyc, k + 19202);
        check("big_busy_end", int'(b_busy), 0);

        check("pending_writes", wq.size(), 0);
        check("pending_done", dq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
